// File: rtl/hist_pkg.sv
// rtl/hist_pkg.sv - shared encodings and defaults for the histogram scratch arbiter
package hist_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCK_A = 1'b1
   } state_t;

   typedef enum logic {
      OWN_A = 1'b0,
      OWN_B = 1'b1
   } owner_t;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_RD_LAT = 3;

endpackage

// File: rtl/hist_rd_tag_pipe.sv
// rtl/hist_rd_tag_pipe.sv - RD_LAT-deep valid/owner tag pipeline aligning read returns to their requester
module hist_rd_tag_pipe
   import hist_pkg::*;
#(
   parameter int RD_LAT = DEF_RD_LAT
) (
   input  logic   clock,
   input  logic   reset,
   input  logic   in_valid,
   input  owner_t in_owner,
   output logic   out_valid,
   output owner_t out_owner
);

   logic [RD_LAT-1:0] valid_q;
   logic [RD_LAT-1:0] owner_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= '0;
         owner_q <= '0;
      end else begin
         valid_q[0] <= in_valid;
         owner_q[0] <= in_owner;
         for (int i = 1; i < RD_LAT; i++) begin
            valid_q[i] <= valid_q[i-1];
            owner_q[i] <= owner_q[i-1];
         end
      end
   end

   assign out_valid = valid_q[RD_LAT-1];
   assign out_owner = owner_t'(owner_q[RD_LAT-1]);

endmodule

// File: rtl/histogram_scratch_arbiter.sv
// rtl/histogram_scratch_arbiter.sv - two-requester scratch memory arbiter with A-side RMW lock
// Optional HIST_ARB_ROUND_ROBIN_EN: alternate A/B on IDLE contention instead of fixed A priority.
module histogram_scratch_arbiter
   import hist_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int RD_LAT = DEF_RD_LAT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              a_req,
   input  logic              a_we,
   input  logic              a_lock,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              locked
);

   state_t state, state_next;

`ifdef HIST_ARB_ROUND_ROBIN_EN
   owner_t last_owner;

   always_ff @(posedge clock) begin
      if (reset)
         last_owner <= OWN_B;
      else if (a_gnt)
         last_owner <= OWN_A;
      else if (b_gnt)
         last_owner <= OWN_B;
   end
`endif

   always_ff @(posedge clock) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Grants are gated by reset so nothing reaches memory while reset is held.
   always_comb begin
      state_next = state;
      a_gnt      = 1'b0;
      b_gnt      = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: begin
               if (a_req && b_req) begin
`ifdef HIST_ARB_ROUND_ROBIN_EN
                  if (last_owner == OWN_A)
                     b_gnt = 1'b1;
                  else
                     a_gnt = 1'b1;
`else
                  a_gnt = 1'b1;
`endif
               end else begin
                  a_gnt = a_req;
                  b_gnt = b_req;
               end
               if (a_gnt && a_lock)
                  state_next = LOCK_A;
            end
            LOCK_A: begin
               a_gnt = a_req;
               if (!a_lock)
                  state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      mem_en    = a_gnt | b_gnt;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (a_gnt) begin
         mem_we    = a_we;
         mem_addr  = a_addr;
         mem_wdata = a_wdata;
      end else if (b_gnt) begin
         mem_we    = b_we;
         mem_addr  = b_addr;
         mem_wdata = b_wdata;
      end
   end

   assign locked = (state == LOCK_A);

   logic   tag_valid;
   owner_t tag_owner;

   hist_rd_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_tag_pipe (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (mem_en & ~mem_we),
      .in_owner  (b_gnt ? OWN_B : OWN_A),
      .out_valid (tag_valid),
      .out_owner (tag_owner)
   );

   assign a_rvalid = tag_valid && (tag_owner == OWN_A);
   assign b_rvalid = tag_valid && (tag_owner == OWN_B);

   // Memory data arrives in the return cycle; the held copy covers the idle cycles.
   logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         if (a_rvalid)
            a_rdata_q <= mem_rdata;
         if (b_rvalid)
            b_rdata_q <= mem_rdata;
      end
   end

   assign a_rdata = a_rvalid ? mem_rdata : a_rdata_q;
   assign b_rdata = b_rvalid ? mem_rdata : b_rdata_q;

endmodule

// File: tb/tb_histogram_scratch_arbiter.sv
// tb/tb_histogram_scratch_arbiter.sv - scoreboard bench for histogram_scratch_arbiter
module tb_histogram_scratch_arbiter;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;
   localparam int RD_LAT = 3;
`ifdef HIST_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              a_req = 1'b0, a_we = 1'b0, a_lock = 1'b0;
   logic [ADDR_W-1:0] a_addr = '0;
   logic [DATA_W-1:0] a_wdata = '0;
   logic              a_gnt, a_rvalid;
   logic [DATA_W-1:0] a_rdata;
   logic              b_req = 1'b0, b_we = 1'b0;
   logic [ADDR_W-1:0] b_addr = '0;
   logic [DATA_W-1:0] b_wdata = '0;
   logic              b_gnt, b_rvalid;
   logic [DATA_W-1:0] b_rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              locked;

   histogram_scratch_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .a_req     (a_req),
      .a_we      (a_we),
      .a_lock    (a_lock),
      .a_addr    (a_addr),
      .a_wdata   (a_wdata),
      .a_gnt     (a_gnt),
      .a_rvalid  (a_rvalid),
      .a_rdata   (a_rdata),
      .b_req     (b_req),
      .b_we      (b_we),
      .b_addr    (b_addr),
      .b_wdata   (b_wdata),
      .b_gnt     (b_gnt),
      .b_rvalid  (b_rvalid),
      .b_rdata   (b_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .locked    (locked)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Scratch memory model: fixed contents loaded during reset, RD_LAT-cycle read return.
   logic [DATA_W-1:0] mem [256];
   logic [DATA_W-1:0] rd_pipe [RD_LAT];

   function automatic logic [DATA_W-1:0] init_val(input int addr);
      case (addr)
         8'h01:   return 32'h0000_0011;
         8'h02:   return 32'h0000_0022;
         8'h03:   return 32'h0000_0033;
         8'h05:   return 32'h0000_002A;
         8'h10:   return 32'h0000_0100;
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clock) begin
      for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
      rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : 32'hDEAD_BEEF;
      if (reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      end else if (mem_en && mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end
   assign mem_rdata = rd_pipe[RD_LAT-1];

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   typedef struct {
      logic              owner;
      logic [DATA_W-1:0] data;
      int                cyc;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   task automatic expect_read(input logic owner, input logic [DATA_W-1:0] data);
      sb.push_back('{owner, data, cyc + RD_LAT});
   endtask

   always @(negedge clock) begin
      if (a_rvalid === 1'b1 || b_rvalid === 1'b1) begin
         if (a_rvalid && b_rvalid) check("dual_rvalid", 2'b11, 2'b01);
         if (sb.size() == 0) begin
            check("unexpected_rvalid", {b_rvalid, a_rvalid}, 2'b00);
         end else begin
            mon_e = sb.pop_front();
            check("rv_owner", b_rvalid, mon_e.owner);
            check("rv_data", b_rvalid ? b_rdata : a_rdata, mon_e.data);
            check("rv_cycle", cyc, mon_e.cyc);
         end
      end
   end

   task automatic step(input logic ar, input logic aw, input logic al, input logic [7:0] aa,
                       input logic [31:0] ad, input logic br, input logic bw,
                       input logic [7:0] ba, input logic [31:0] bd);
      @(posedge clock);
      #1;
      a_req = ar; a_we = aw; a_lock = al; a_addr = aa; a_wdata = ad;
      b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
   endtask

   task automatic check_quiet(input string name);
      check(name, {a_gnt, b_gnt, mem_en, mem_we, locked, a_rvalid, b_rvalid}, 7'b0);
      check({name, "_rdata"}, {a_rdata, b_rdata}, 64'h0);
      check({name, "_mem"}, {mem_addr, mem_wdata}, 40'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      logic exp_a;

      // Requests held high during reset must not be granted.
      a_req = 1'b1; b_req = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reset_no_grant", {a_gnt, b_gnt, mem_en}, 3'b000);
      @(posedge clock);
      #1;
      reset = 1'b0; a_req = 1'b0; b_req = 1'b0;
      @(negedge clock);
      check_quiet("after_reset");

      // Single A read, return at RD_LAT.
      step(1, 0, 0, 8'h05, 32'h0, 0, 0, 8'h00, 32'h0);
      check("a_read_gnt", {a_gnt, b_gnt, mem_en, mem_we, mem_addr}, {4'b1010, 8'h05});
      expect_read(1'b0, 32'h0000_002A);
      idle(1);
      check("idle_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 42'h0);
      idle(4);
      check("a_rdata_hold", a_rdata, 32'h0000_002A);

      // Locked read-modify-write with B contending throughout.
      step(1, 0, 1, 8'h10, 32'h0, 1, 0, 8'h10, 32'h0);
      check("lock_rd_gnt", {a_gnt, b_gnt, locked}, 3'b100);
      expect_read(1'b0, 32'h0000_0100);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 8'h10, 32'h0, 1, 0, 8'h10, 32'h0);
         check("lock_wait", {a_gnt, b_gnt, mem_en, locked}, 4'b0001);
      end
      step(1, 1, 0, 8'h10, 32'h101, 1, 0, 8'h10, 32'h0);
      check("lock_wr", {a_gnt, b_gnt, locked, mem_we}, 4'b1011);
      check("lock_wr_data", {mem_addr, mem_wdata}, {8'h10, 32'h101});
      step(0, 0, 0, 8'h00, 32'h0, 1, 0, 8'h10, 32'h0);
      check("unlock_b_gnt", {a_gnt, b_gnt, locked}, 3'b010);
      expect_read(1'b1, 32'h0000_0101);
      idle(5);

      // Contention: fixed A priority, or A,B,A,B when alternating.
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 8'h01, 32'h0, 1, 0, 8'h02, 32'h0);
         exp_a = RR ? (i % 2 == 0) : 1'b1;
         check("contend_gnt", {a_gnt, b_gnt}, {exp_a, ~exp_a});
         if (exp_a) expect_read(1'b0, 32'h0000_0011);
         else       expect_read(1'b1, 32'h0000_0022);
      end
      idle(5);

      // Interleaved owners on consecutive cycles.
      step(1, 0, 0, 8'h01, 32'h0, 0, 0, 8'h00, 32'h0);
      check("il_gnt0", {a_gnt, b_gnt}, 2'b10);
      expect_read(1'b0, 32'h0000_0011);
      step(0, 0, 0, 8'h00, 32'h0, 1, 0, 8'h02, 32'h0);
      check("il_gnt1", {a_gnt, b_gnt}, 2'b01);
      expect_read(1'b1, 32'h0000_0022);
      step(1, 0, 0, 8'h03, 32'h0, 0, 0, 8'h00, 32'h0);
      check("il_gnt2", {a_gnt, b_gnt}, 2'b10);
      expect_read(1'b0, 32'h0000_0033);
      idle(5);
      check("b_rdata_hold", b_rdata, 32'h0000_0022);

      // Reset one cycle after an A read grant discards the read.
      step(1, 0, 0, 8'h05, 32'h0, 0, 0, 8'h00, 32'h0);
      check("pre_reset_gnt", a_gnt, 1'b1);
      @(posedge clock);
      #1;
      reset = 1'b1; a_req = 1'b0;
      @(negedge clock);
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check_quiet("mid_op_reset");
      idle(6);

      // B clear sweep over every address with A idle.
      for (int i = 0; i < 256; i++) begin
         step(0, 0, 0, 8'h00, 32'h0, 1, 1, i[7:0], 32'h0);
         check("sweep", {b_gnt, a_gnt, mem_en, mem_we, mem_addr, mem_wdata},
               {4'b1011, i[7:0], 32'h0});
      end
      step(1, 0, 0, 8'h05, 32'h0, 0, 0, 8'h00, 32'h0);
      check("post_sweep_gnt", a_gnt, 1'b1);
      expect_read(1'b0, 32'h0);
      idle(6);

      check("scoreboard_drain", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/histogram_scratch_arbiter.md
HISTOGRAM_SCRATCH_ARBITER -- requirements
Module: histogram_scratch_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, scratch memory address width (one line per histogram bin).
REQ-002 Parameter DATA_W, default 32, bin count width.
REQ-003 Parameter RD_LAT, default 3, fixed scratch memory read latency in cycles; legal range 1..7.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 a_req, a_we, a_lock  input  1 each  histogram-update requester: request, write enable, hold ownership for read-modify-write.
REQ-007 a_addr  input  ADDR_W, a_wdata  input  DATA_W  histogram requester address and write data.
REQ-008 a_gnt  output  1, a_rvalid  output  1, a_rdata  output  DATA_W  histogram grant and read return.
REQ-009 b_req, b_we  input  1 each; b_addr  input  ADDR_W; b_wdata  input  DATA_W  readout/clear requester.
REQ-010 b_gnt  output  1, b_rvalid  output  1, b_rdata  output  DATA_W  readout grant and read return.
REQ-011 mem_en, mem_we  output  1; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_rdata  input  DATA_W  scratch memory port.
REQ-012 locked  output  1  high while state is LOCK_A.

Function
REQ-013 At most one memory operation SHALL issue per cycle; a_gnt and b_gnt SHALL never be high together.
REQ-014 Grants SHALL be combinational from current state and requests; a granted request drives mem_en=1, mem_we, mem_addr and mem_wdata from its requester in the same cycle.
REQ-015 With no grant, mem_en=0, mem_we=0, and mem_addr/mem_wdata SHALL hold 0.
REQ-016 States: IDLE, LOCK_A. IDLE->LOCK_A when A is granted with a_lock=1; LOCK_A->IDLE on the first cycle a_lock=0 after entry, with that cycle's A operation still granted if a_req=1.
REQ-017 In LOCK_A, only A SHALL be granted; b_req waits with b_gnt=0.
REQ-018 In IDLE with a single requester, that requester SHALL be granted.
REQ-019 In IDLE with both requesting, A SHALL win (fixed priority) unless REQ-029 applies.
REQ-020 Every granted read (we=0) SHALL return mem_rdata on the owner's rdata with a one-cycle rvalid exactly RD_LAT cycles after the grant cycle, via an RD_LAT-deep tag pipeline (valid bit plus owner bit).
REQ-021 Writes SHALL produce no rvalid.
REQ-022 Back-to-back reads, including reads interleaved between owners, SHALL each return in order at RD_LAT with the correct owner.
REQ-023 rdata SHALL hold its last value when rvalid=0.
REQ-024 Requests SHALL not be queued; an ungranted requester holds req/addr/data until granted.

Reset
REQ-025 When reset is high, state SHALL become IDLE, the tag pipeline SHALL clear, and a_rvalid, b_rvalid, locked, a_gnt, b_gnt and mem_en SHALL all be 0 in the following cycle.
REQ-026 a_rdata and b_rdata SHALL reset to 0.
REQ-027 Reads in flight when reset asserts mid-operation SHALL be discarded; no rvalid SHALL appear for them after reset releases.
REQ-028 While reset is high, no grant SHALL issue, regardless of requests.

Configuration
REQ-029 With macro HIST_ARB_ROUND_ROBIN_EN defined, IDLE contention SHALL alternate. The last-granted owner register resets to B, so the first contention goes to A, and every grant updates the register. Without the macro, fixed A priority applies and the register is absent. LOCK_A behaviour is identical in both builds.

Structure
REQ-030 Package hist_pkg SHALL hold the state encoding (IDLE, LOCK_A), the owner encoding (OWN_A=0, OWN_B=1) and default parameter constants.
REQ-031 The read-return tag pipeline SHALL be the sub-module hist_rd_tag_pipe, parameterised by RD_LAT.

Verification
REQ-032 a_req read addr 0x05, mem returns 0x0000002A: a_gnt in cycle 0, a_rvalid=1 with a_rdata=0x2A in cycle 3, b_rvalid=0 throughout.
REQ-033 Run a lock sequence:
- A reads 0x10 with a_lock=1 while b_req=1 every cycle, then A writes 0x10 data+1 with a_lock=0.
- Required response: b_gnt=0 until the cycle after the write; locked=1 only between these operations.
REQ-034 Fixed priority: a_req and b_req both high for 4 cycles with no lock -> a_gnt in all 4 cycles. Round-robin build: grants alternate A, B, A, B.
REQ-035 Interleaved reads A@0x01, B@0x02, A@0x03 on consecutive cycles -> rvalids on cycles 3, 4, 5 to A, B, A with the matching data.
REQ-036 Reset asserted one cycle after an A read grant -> no a_rvalid at any later cycle; all outputs 0 after reset.
REQ-037 B write-only clear sweep of 256 addresses with A idle -> 256 consecutive b_gnt cycles, mem_we=1, zero rvalids.
